seq_calc_core: RTL and testbench

- Parametrised successor of the button-driven calculator top level.
- Operands are entered serially on Din, each accepted on a press of next; the operation is selected on MS and launched with a further press.
- Adds width generalisation, an iterative multiplier, logic ops, overflow/error flags, and re-execution on the same operands without reloading.
- Sits between the board input debouncers and the display driver.

---
 rtl/seq_calc_core.sv | 143 ++++++++++++++
 tb/tb_seq_calc_core.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seq_calc_core.sv
// seq_calc_core: serial-entry calculator FSM with shift-add multiplier and flags.
// Define CALC_DIV_EN to add a restoring divider on op 111 (otherwise 111 is invalid).
module seq_calc_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             next,
  input  logic [2:0]       MS,
  input  logic [WIDTH-1:0] Din,
  output logic             Done_out,
  output logic [2:0]       CS_out,
  output logic [WIDTH-1:0] Alu_out,
  output logic             Ovf_out,
  output logic             Err_out
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [2:0] {
    WAIT_A = 3'd0, WAIT_B = 3'd1, WAIT_OP = 3'd2, EXEC = 3'd3, DONE = 3'd4
  } state_t;
  state_t state_q, state_d;
  logic next_q, press, last, ovf_q, ovf_d, err_q, err_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, p_init;
  logic [2:0] op_q, op_d;
  logic [2*WIDTH-1:0] p_q, p_d, mul_step;
  logic [WIDTH:0] mul_sum, add_sum;
  logic [CW-1:0] cnt_q, cnt_d;
  assign press = next & ~next_q;
  assign last = cnt_q == CW'(WIDTH - 1);
  assign add_sum = {1'b0, a_q} + {1'b0, b_q};
  // p holds {partial high half, remaining multiplier bits}, shifted right each step
  assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
  assign mul_step = {mul_sum, p_q[WIDTH-1:1]};
`ifdef CALC_DIV_EN
  logic [WIDTH:0] rem_sh, rem_sub;
  logic [2*WIDTH-1:0] div_step;
  // divide reuses p as {remainder, dividend/quotient}; a borrow means no subtract
  assign rem_sh = p_q[2*WIDTH-1:WIDTH-1];
  assign rem_sub = rem_sh - {1'b0, b_q};
  assign div_step = rem_sub[WIDTH] ? {rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                   : {rem_sub[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
  assign p_init = (MS == 3'b111) ? a_q : b_q;
`else
  assign p_init = b_q;
`endif
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    p_d = p_q;
    cnt_d = cnt_q;
    alu_d = alu_q;
    ovf_d = ovf_q;
    err_d = err_q;
    case (state_q)
      WAIT_A: if (press) begin
        a_d = Din;
        state_d = WAIT_B;
      end
      WAIT_B: if (press) begin
        b_d = Din;
        state_d = WAIT_OP;
      end
      WAIT_OP, DONE: if (press) begin
        op_d = MS;
        ovf_d = 1'b0;
        err_d = 1'b0;
        cnt_d = '0;
        p_d = {{WIDTH{1'b0}}, p_init};
        state_d = EXEC;
      end
      EXEC: begin
        state_d = DONE;
        case (op_q)
          3'b001: begin
            alu_d = add_sum[WIDTH-1:0];
            ovf_d = add_sum[WIDTH];
          end
          3'b010: begin
            alu_d = a_q - b_q;
            ovf_d = a_q < b_q;
          end
          3'b011: begin
            p_d = mul_step;
            cnt_d = cnt_q + 1'b1;
            alu_d = last ? mul_step[WIDTH-1:0] : alu_q;
            ovf_d = last & (|mul_step[2*WIDTH-1:WIDTH]);
            state_d = last ? DONE : EXEC;
          end
          3'b100: alu_d = a_q & b_q;
          3'b101: alu_d = a_q | b_q;
          3'b110: alu_d = a_q ^ b_q;
`ifdef CALC_DIV_EN
          3'b111: if (b_q == '0) begin
            err_d = 1'b1;
            alu_d = '1;
          end else begin
            p_d = div_step;
            cnt_d = cnt_q + 1'b1;
            alu_d = last ? div_step[WIDTH-1:0] : alu_q;
            state_d = last ? DONE : EXEC;
          end
`endif
          default: begin
            err_d = 1'b1;
            alu_d = '0;
          end
        endcase
      end
      default: state_d = WAIT_A;
    endcase
  end
  always_ff @(posedge clk) begin
    next_q <= next;
    if (clear) begin
      state_q <= WAIT_A;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      p_q <= '0;
      cnt_q <= '0;
      alu_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      p_q <= p_d;
      cnt_q <= cnt_d;
      alu_q <= alu_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end
  assign Done_out = state_q == DONE;
  assign CS_out = state_q;
  assign Alu_out = alu_q;
  assign Ovf_out = ovf_q;
  assign Err_out = err_q;
endmodule

// File: tb/tb_seq_calc_core.sv
// tb_seq_calc_core: randomized self-checking bench against an arithmetic reference model.
module tb_seq_calc_core;
  localparam int W = 16;
  logic clk = 1'b0, clear = 1'b1, next = 1'b0;
  logic [2:0] MS = 3'd0;
  logic [W-1:0] Din = '0;
  logic Done_out, Ovf_out, Err_out;
  logic [2:0] CS_out;
  logic [W-1:0] Alu_out;
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] exp_alu = '0;
  seq_calc_core #(.WIDTH(W)) dut (
    .clk(clk), .clear(clear), .next(next), .MS(MS), .Din(Din),
    .Done_out(Done_out), .CS_out(CS_out), .Alu_out(Alu_out),
    .Ovf_out(Ovf_out), .Err_out(Err_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model(input logic [W-1:0] a, b, input logic [2:0] op,
                       output logic [W-1:0] r, output logic o, e, output int lat);
    longint unsigned wa = a, wb = b, full = 0;
    r = '0; o = 1'b0; e = 1'b0; lat = 1;
    case (op)
      3'd1: begin full = wa + wb; r = W'(full); o = (full >> W) != 0; end
      3'd2: begin r = W'(wa - wb); o = wa < wb; end
      3'd3: begin full = wa * wb; r = W'(full); o = (full >> W) != 0; lat = W; end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
`ifdef CALC_DIV_EN
      3'd7: if (wb == 0) begin e = 1'b1; r = '1; end
            else begin r = W'(wa / wb); lat = W; end
`endif
      default: e = 1'b1;
    endcase
  endtask
  task automatic do_clear();
    clear = 1'b1; next = 1'b0;
    tick();
    clear = 1'b0;
    exp_alu = '0;
  endtask
  task automatic push(input logic [W-1:0] d);
    Din = d; next = 1'b1;
    tick();
    next = 1'b0;
    tick();
  endtask
  task automatic load(input logic [W-1:0] a, b);
    check("cs_wait_a", CS_out, 0);
    push(a);
    check("cs_wait_b", CS_out, 1);
    push(b);
    check("cs_wait_op", CS_out, 2);
    check("alu_held_on_load", Alu_out, exp_alu);
  endtask
  task automatic launch(input logic [2:0] op, input logic [W-1:0] a, b);
    logic [W-1:0] r;
    logic o, e;
    int lat, n;
    model(a, b, op, r, o, e, lat);
    MS = op; next = 1'b1;
    tick();
    next = 1'b0;
    check("cs_exec", CS_out, 3);
    check("done_low_in_exec", Done_out, 0);
    n = 0;
    while (!Done_out && n < 100) begin
      tick();
      n++;
      if (n == 2 && lat > 2) check("alu_hidden", Alu_out, exp_alu);
    end
    check("latency", n, lat);
    check("cs_done", CS_out, 4);
    check("alu", Alu_out, r);
    check("ovf", Ovf_out, o);
    check("err", Err_out, e);
    exp_alu = r;
  endtask
  initial begin
    logic [W-1:0] a, b;
    do_clear();
    check("rst_cs", CS_out, 0);
    check("rst_done", Done_out, 0);
    check("rst_alu", Alu_out, 0);
    check("rst_ovf", Ovf_out, 0);
    check("rst_err", Err_out, 0);
    load(1, 3); launch(3'b001, 1, 3);
    check("add_1_3", Alu_out, 4);
    do_clear(); load(133, 4); launch(3'b011, 133, 4);
    check("mul_133_4", Alu_out, 532);
    launch(3'b010, 133, 4);
    check("sub_reexec", Alu_out, 129);
    do_clear(); load(16'hFFFF, 1); launch(3'b001, 16'hFFFF, 1);
    do_clear(); load(2, 5); launch(3'b010, 2, 5);
    do_clear(); load(16'h0100, 16'h0100); launch(3'b011, 16'h0100, 16'h0100);
    launch(3'b000, 16'h0100, 16'h0100);
    launch(3'b111, 16'h0100, 16'h0100);
    do_clear(); load(133, 4); launch(3'b111, 133, 4);
    do_clear(); load(7, 0); launch(3'b111, 7, 0);
    // a long hold loads only A, even though Din keeps changing
    do_clear();
    Din = 16'h0055; next = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      Din = W'($urandom);
    end
    check("hold_cs", CS_out, 1);
    next = 1'b0;
    tick();
    push(7);
    check("hold_cs_op", CS_out, 2);
    launch(3'b001, 16'h0055, 7);
    // clear mid-multiply, after a nonzero result is already latched
    do_clear(); load(16'h1234, 16'h5678); launch(3'b001, 16'h1234, 16'h5678);
    MS = 3'b011; next = 1'b1;
    tick();
    next = 1'b0;
    repeat (7) tick();
    check("mid_mul_cs", CS_out, 3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_cs", CS_out, 0);
    check("clr_alu", Alu_out, 0);
    check("clr_done", Done_out, 0);
    check("clr_ovf", Ovf_out, 0);
    check("clr_err", Err_out, 0);
    exp_alu = '0;
    next = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (3) tick();
    check("held_through_clear", CS_out, 0);
    next = 1'b0;
    tick();
    for (int i = 0; i < 25; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      do_clear();
      load(a, b);
      repeat ($urandom_range(1, 3)) launch(3'($urandom_range(0, 7)), a, b);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
